// File: rtl/median_pkg.sv
// Shared constants, FSM state encoding and 3x3 tap offsets for the median window sequencer.
// Pure definitions; no logic, no latency, no flow control.
package median_pkg;

  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;
  localparam int DEF_ADDR_W = 19;
  localparam int NUM_TAPS   = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FILT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Tap k covers row k/3-1 and column k%3-1 of the neighbourhood.
  function automatic logic signed [1:0] tap_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: tap_dx = -2'sd1;
      4'd1, 4'd4, 4'd7: tap_dx = 2'sd0;
      default:          tap_dx = 2'sd1;
    endcase
  endfunction

  function automatic logic signed [1:0] tap_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: tap_dy = -2'sd1;
      4'd3, 4'd4, 4'd5: tap_dy = 2'sd0;
      default:          tap_dy = 2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/median_tap_addr.sv
// Combinational tap address for window centre (x,y) and tap k; zero latency, no flow control.
// MEDIAN_BORDER_CLAMP_EN clamps border taps onto the frame and never flags them out of range.
module median_tap_addr
  import median_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int XW     = $clog2(DEF_IMG_W),
  parameter int YW     = $clog2(DEF_IMG_H)
) (
  input  logic [XW-1:0]     i_x,
  input  logic [YW-1:0]     i_y,
  input  logic [3:0]        i_k,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_oor
);

  // Two spare bits: one for sign, one so x+1 at the right edge cannot overflow.
  localparam int CW = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [CW-1:0] XMAX = CW'(IMG_W - 1);
  localparam logic signed [CW-1:0] YMAX = CW'(IMG_H - 1);

  logic signed [1:0]    w_dx;
  logic signed [1:0]    w_dy;
  logic signed [CW-1:0] w_sx;
  logic signed [CW-1:0] w_sy;
  logic signed [CW-1:0] w_cx;
  logic signed [CW-1:0] w_cy;

  assign w_dx = tap_dx(i_k);
  assign w_dy = tap_dy(i_k);
  assign w_sx = $signed({{(CW-XW){1'b0}}, i_x}) + $signed({{(CW-2){w_dx[1]}}, w_dx});
  assign w_sy = $signed({{(CW-YW){1'b0}}, i_y}) + $signed({{(CW-2){w_dy[1]}}, w_dy});

`ifdef MEDIAN_BORDER_CLAMP_EN
  assign w_cx  = w_sx[CW-1] ? '0 : ((w_sx > XMAX) ? XMAX : w_sx);
  assign w_cy  = w_sy[CW-1] ? '0 : ((w_sy > YMAX) ? YMAX : w_sy);
  assign o_oor = 1'b0;
`else
  assign w_cx  = w_sx;
  assign w_cy  = w_sy;
  assign o_oor = w_sx[CW-1] || (w_sx > XMAX) || w_sy[CW-1] || (w_sy > YMAX);
`endif

  assign o_addr = ADDR_W'(w_cy) * ADDR_W'(IMG_W) + ADDR_W'(w_cx);

endmodule

// File: rtl/median_window_sequencer.sv
// Raster-order read/load/filter/write sequencing for a 3x3 median filter; MEDIAN_BORDER_CLAMP_EN picks clamp vs zero-fill borders.
// At least 12+RD_LAT cycles per pixel; waits in FILT for flt_done and holds wr_en/wr_addr in WRITE until wr_ready.
module median_window_sequencer
  import median_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              ld_tap,
  output logic [3:0]        tap_sel,
  output logic              tap_zero,
  output logic              flt_start,
  input  logic              flt_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ready
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              r_state;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [3:0]          r_k;
  logic [DW-1:0]       r_drn;
  logic                r_flt_issued;
  logic [ADDR_W-1:0]   r_pix_addr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_dl_vld  [RD_LAT];
  logic [3:0]          r_dl_k    [RD_LAT];
  logic                r_dl_zero [RD_LAT];

  logic                w_fetch;
  logic                w_rd;
  logic                w_oor;
  logic                w_last_x;
  logic                w_last_y;
  logic [ADDR_W-1:0]   w_tap_addr;

  median_tap_addr #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_tap_addr (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_k    (r_k),
    .o_addr (w_tap_addr),
    .o_oor  (w_oor)
  );

  assign w_fetch  = (r_state == ST_FETCH);
  assign w_rd     = w_fetch && !w_oor;
  assign w_last_x = (r_x == XW'(IMG_W - 1));
  assign w_last_y = (r_y == YW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_k          <= '0;
      r_drn        <= '0;
      r_flt_issued <= 1'b0;
      r_pix_addr   <= '0;
      r_rd_addr    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_dl_vld[i]  <= 1'b0;
        r_dl_k[i]    <= '0;
        r_dl_zero[i] <= 1'b0;
      end
    end else begin
      if (w_rd) r_rd_addr <= w_tap_addr;
      // Tap index and zero flag ride alongside the memory latency, read or not.
      r_dl_vld[0]  <= w_fetch;
      r_dl_k[0]    <= r_k;
      r_dl_zero[0] <= w_fetch && w_oor;
      for (int i = 1; i < RD_LAT; i++) begin
        r_dl_vld[i]  <= r_dl_vld[i-1];
        r_dl_k[i]    <= r_dl_k[i-1];
        r_dl_zero[i] <= r_dl_zero[i-1];
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_FETCH;
            r_x        <= '0;
            r_y        <= '0;
            r_k        <= '0;
            r_pix_addr <= '0;
          end
        end
        ST_FETCH: begin
          if (r_k == 4'(NUM_TAPS - 1)) begin
            r_k     <= '0;
            r_drn   <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (r_drn == DW'(RD_LAT - 1)) begin
            r_flt_issued <= 1'b0;
            r_state      <= ST_FILT;
          end else begin
            r_drn <= r_drn + DW'(1);
          end
        end
        ST_FILT: begin
          r_flt_issued <= 1'b1;
          if (flt_done) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wr_ready) r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (w_last_x && w_last_y) begin
            r_state <= ST_DONE;
          end else begin
            if (w_last_x) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
            end else begin
              r_x <= r_x + XW'(1);
            end
            // Raster order makes the output address a plain running count.
            r_pix_addr <= r_pix_addr + ADDR_W'(1);
            r_k        <= '0;
            r_state    <= ST_FETCH;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign rd_en     = w_rd;
  assign rd_addr   = w_rd ? w_tap_addr : r_rd_addr;
  assign ld_tap    = r_dl_vld[RD_LAT-1];
  assign tap_sel   = r_dl_vld[RD_LAT-1] ? r_dl_k[RD_LAT-1] : 4'd0;
  assign tap_zero  = r_dl_zero[RD_LAT-1];
  assign flt_start = (r_state == ST_FILT) && !r_flt_issued;
  assign wr_en     = (r_state == ST_WRITE);
  assign wr_addr   = r_pix_addr;

endmodule
